contador_mod_n: RTL and testbench
=================================

# contador_mod_n

Parametrised synchronous modulo-N counter, successor to the fixed 0..4 ripple counter. Counts 0..MODULO-1 up or down with enable, synchronous clear and parallel load, and exposes registered terminal-count and wrap flags so several instances can be cascaded into multi-digit counters (e.g. display/timer digits). Fully synchronous to one clock; no derived clocks, no ripple stages.

## Interface

Parameters:
- `WIDTH`, default 3: width of the count register; must satisfy 2**WIDTH >= MODULO.
- `MODULO`, default 5: number of states; legal range 2..2**WIDTH.

Ports:
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset. Asserted (0) forces every register to its reset value immediately; deassertion is sampled on the next `clock` rising edge.
- `enable`, in, 1: count one step this cycle.
- `up_down`, in, 1: 1 = count up, 0 = count down.
- `clear`, in, 1: synchronous clear to 0.
- `load`, in, 1: synchronous parallel load.
- `load_value`, in, WIDTH: value for `load`.
- `S`, out, WIDTH: current count.
- `terminal`, out, 1: registered; 1 while `S` equals the terminal value for the current direction (MODULO-1 up, 0 down).
- `wrap`, out, 1: registered one-cycle pulse, 1 in the cycle after a wrap step.
- `load_error`, out, 1: registered one-cycle pulse, 1 in the cycle after an out-of-range load.

## Operation

- Reset values: `S`=0, `terminal`=0 (direction unknown until first edge), `wrap`=0, `load_error`=0.
- Priority per edge: `clear` > `load` > `enable` > hold.
- `clear`: `S`←0; `wrap`←0; `load_error`←0.
- `load` with `load_value` < MODULO: `S`←`load_value`. With `load_value` >= MODULO: `S`←0, `load_error`←1.
- `enable`, up: `S`←`S`+1, except `S`=MODULO-1 → 0 with `wrap`←1.
- `enable`, down: `S`←`S`-1, except `S`=0 → MODULO-1 with `wrap`←1.
- Otherwise `S` holds; `wrap` and `load_error` return to 0.
- `terminal` is recomputed each edge from next `S` and current `up_down`; toggling `up_down` while idle updates `terminal` on the following edge.
- Arithmetic is WIDTH bits; no intermediate value may exceed MODULO-1 (compare before increment, never rely on 2**WIDTH overflow unless MODULO = 2**WIDTH, where both forms coincide).
- Cascading: next digit's `enable` = this digit's `enable` AND `terminal`; `wrap` is informational only.

## Timing

- All outputs registered; latency one clock from any control input to `S`, `terminal`, `wrap`, `load_error`.
- `enable` held high: one step per cycle, full cycle in MODULO clocks, `wrap` high exactly once per cycle.
- Simultaneous `clear`+`load`+`enable`: clear wins; no wrap, no error.
- `load` at the terminal value with `enable` high: load wins, no wrap.
- `reset` asserted mid-count: outputs at reset values within the same cycle, independent of `clock`; counting resumes from 0 at first edge after release.
- Direction change at terminal: up at MODULO-1 then `up_down`=0 with `enable` → `S`=MODULO-2, no wrap.

## Structure

- Shared package: direction constants (`DIR_UP`=1, `DIR_DOWN`=0) and a width helper (`clog2`) for instantiating with MODULO only.
- One natural sub-module: `mod_n_step`, combinational next-value/wrap computation (inputs `S`, `up_down`, outputs next count and wrap flag), reusable by other counters; register and priority logic stay in `contador_mod_n`.
- Elaboration check: flag an error if MODULO < 2 or MODULO > 2**WIDTH.

## Test plan

- Defaults, reset low then high, `enable`=1, `up_down`=1 for 12 edges → `S`: 1,2,3,4,0,1,2,3,4,0,1,2; `wrap` high after each 4→0; `terminal` high while `S`=4.
- Defaults, `up_down`=0, `enable`=1 from 0 → `S`: 4,3,2,1,0,4; `wrap` after 0→4; `terminal` high while `S`=0.
- `load`=1, `load_value`=3 → `S`=3; then `load_value`=6 → `S`=0, `load_error`=1 for one cycle only.
- `S`=4, `clear`, `load`(2), `enable` all high same edge → `S`=0, `wrap`=0, `load_error`=0.
- WIDTH=4, MODULO=10, two cascaded instances, 25 enabled edges from reset → low digit 5, high digit 2; high digit increments only on low digit 9→0.
- Reset pulled low asynchronously mid-cycle with `S`=3 → `S`=0 and flags 0 before next edge; first enabled edge after release → `S`=1.

Source files
------------

// File: rtl/contador_mod_n_pkg.sv
// rtl/contador_mod_n_pkg.sv - shared direction constants and width helper for mod-N counters
package contador_mod_n_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Smallest width whose range covers n states (minimum 1 bit).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_mod_n_if.sv
// rtl/contador_mod_n_if.sv - control and status bundle of one counter digit
interface contador_mod_n_if #(
  parameter int WIDTH = 3
);

  logic             enable;
  logic             up_down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] S;
  logic             terminal;
  logic             wrap;
  logic             load_error;

  modport master (
    output enable, up_down, clear, load, load_value,
    input  S, terminal, wrap, load_error
  );

  modport slave (
    input  enable, up_down, clear, load, load_value,
    output S, terminal, wrap, load_error
  );

endinterface

// File: rtl/contador_mod_n_step.sv
// rtl/contador_mod_n_step.sv - combinational mod-N successor/predecessor with wrap flag
module mod_n_step
  import contador_mod_n_pkg::*;
#(
  parameter int MODULO = 5,
  parameter int WIDTH  = 3
) (
  input  logic [WIDTH-1:0] s,
  input  logic             up_down,
  output logic [WIDTH-1:0] s_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  // Boundaries are tested before the +/-1 so no intermediate exceeds MODULO-1.
  always_comb begin
    s_next = s;
    wrap   = 1'b0;
    if (up_down == DIR_UP) begin
      if (s >= MAX_VAL) begin
        s_next = '0;
        wrap   = 1'b1;
      end else begin
        s_next = s + 1'b1;
      end
    end else begin
      if (s == '0) begin
        s_next = MAX_VAL;
        wrap   = 1'b1;
      end else begin
        s_next = s - 1'b1;
      end
    end
  end

endmodule

// File: rtl/contador_mod_n.sv
// rtl/contador_mod_n.sv - cascadable synchronous modulo-N up/down counter
module contador_mod_n
  import contador_mod_n_pkg::*;
#(
  parameter int MODULO = 5,
  parameter int WIDTH  = clog2(MODULO)
) (
  input  logic             clock,
  input  logic             reset,
  contador_mod_n_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("contador_mod_n: MODULO out of range for WIDTH");
  end

  logic [WIDTH-1:0] s_q, s_d;
  logic             terminal_q, terminal_d;
  logic             wrap_q, wrap_d;
  logic             load_error_q, load_error_d;

  logic [WIDTH-1:0] step_next;
  logic             step_wrap;

  mod_n_step #(
    .MODULO (MODULO),
    .WIDTH  (WIDTH)
  ) u_step (
    .s      (s_q),
    .up_down(bus.up_down),
    .s_next (step_next),
    .wrap   (step_wrap)
  );

  always_comb begin
    s_d          = s_q;
    wrap_d       = 1'b0;
    load_error_d = 1'b0;
    if (bus.clear) begin
      s_d = '0;
    end else if (bus.load) begin
      if ({1'b0, bus.load_value} < MOD_EXT) begin
        s_d = bus.load_value;
      end else begin
        s_d          = '0;
        load_error_d = 1'b1;
      end
    end else if (bus.enable) begin
      s_d    = step_next;
      wrap_d = step_wrap;
    end
    // Terminal follows the value being registered and the direction seen now.
    terminal_d = (bus.up_down == DIR_UP) ? (s_d == MAX_VAL) : (s_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_q          <= '0;
      terminal_q   <= 1'b0;
      wrap_q       <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      s_q          <= s_d;
      terminal_q   <= terminal_d;
      wrap_q       <= wrap_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.S          = s_q;
  assign bus.terminal   = terminal_q;
  assign bus.wrap       = wrap_q;
  assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_contador_mod_n.sv
// tb/tb_contador_mod_n.sv - directed self-checking bench for contador_mod_n
module tb_contador_mod_n;

  logic clock;
  logic reset;

  int n_checks;
  int n_fail;

  contador_mod_n_if #(.WIDTH(3)) bus ();
  contador_mod_n_if #(.WIDTH(4)) lo_if ();
  contador_mod_n_if #(.WIDTH(4)) hi_if ();

  contador_mod_n #(.MODULO(5), .WIDTH(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  contador_mod_n #(.MODULO(10), .WIDTH(4)) u_lo (
    .clock(clock),
    .reset(reset),
    .bus  (lo_if)
  );

  contador_mod_n #(.MODULO(10), .WIDTH(4)) u_hi (
    .clock(clock),
    .reset(reset),
    .bus  (hi_if)
  );

  // Next digit steps only when this digit steps from its terminal value.
  assign hi_if.enable     = lo_if.enable & lo_if.terminal;
  assign hi_if.up_down    = 1'b1;
  assign hi_if.clear      = 1'b0;
  assign hi_if.load       = 1'b0;
  assign hi_if.load_value = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int s, input int term, input int wr, input int err);
    check({tag, ".S"}, 32'(bus.S), 32'(s));
    check({tag, ".terminal"}, 32'(bus.terminal), 32'(term));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(wr));
    check({tag, ".load_error"}, 32'(bus.load_error), 32'(err));
  endtask

  int up_seq[12]  = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
  int dn_seq[6]   = '{4, 3, 2, 1, 0, 4};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.enable = 1'b0; bus.up_down = 1'b1; bus.clear = 1'b0;
    bus.load = 1'b0; bus.load_value = '0;
    lo_if.enable = 1'b0; lo_if.up_down = 1'b1; lo_if.clear = 1'b0;
    lo_if.load = 1'b0; lo_if.load_value = '0;

    #12;
    check_all("reset", 0, 0, 0, 0);
    step();
    reset = 1'b1;

    bus.enable = 1'b1; bus.up_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_all($sformatf("up%0d", i), up_seq[i], int'(up_seq[i] == 4), int'(up_seq[i] == 0), 0);
    end

    bus.enable = 1'b0; bus.clear = 1'b1;
    step();
    check_all("clr", 0, 0, 0, 0);
    bus.clear = 1'b0; bus.up_down = 1'b0; bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all($sformatf("dn%0d", i), dn_seq[i], int'(dn_seq[i] == 0), int'(dn_seq[i] == 4), 0);
    end

    bus.enable = 1'b0; bus.up_down = 1'b1; bus.load = 1'b1; bus.load_value = 3'd3;
    step();
    check_all("load3", 3, 0, 0, 0);
    bus.load_value = 3'd6;
    step();
    check_all("load6", 0, 0, 0, 1);
    bus.load = 1'b0;
    step();
    check_all("hold_after_err", 0, 0, 0, 0);

    bus.load = 1'b1; bus.load_value = 3'd4;
    step();
    check_all("load4", 4, 1, 0, 0);
    bus.enable = 1'b1;
    step();
    check_all("load_at_term", 4, 1, 0, 0);
    bus.clear = 1'b1; bus.load_value = 3'd2;
    step();
    check_all("clr_load_en", 0, 0, 0, 0);

    bus.clear = 1'b0; bus.load_value = 3'd4;
    step();
    bus.load = 1'b0; bus.up_down = 1'b0;
    step();
    check_all("dir_change", 3, 0, 0, 0);

    bus.enable = 1'b0; bus.load = 1'b1; bus.load_value = 3'd0;
    step();
    check_all("idle_dn_term", 0, 1, 0, 0);
    bus.load = 1'b0; bus.up_down = 1'b1;
    step();
    check_all("idle_up_term", 0, 0, 0, 0);

    bus.load = 1'b1; bus.load_value = 3'd3;
    step();
    bus.load = 1'b0;
    check("pre_async.S", 32'(bus.S), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    reset = 1'b1;
    bus.enable = 1'b1;
    step();
    check_all("after_rst", 1, 0, 0, 0);

    bus.enable = 1'b0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    lo_if.enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 8) begin
        check("casc9.lo", 32'(lo_if.S), 32'd9);
        check("casc9.hi", 32'(hi_if.S), 32'd0);
      end
      if (i == 9) begin
        check("casc10.lo", 32'(lo_if.S), 32'd0);
        check("casc10.hi", 32'(hi_if.S), 32'd1);
      end
    end
    check("casc25.lo", 32'(lo_if.S), 32'd5);
    check("casc25.hi", 32'(hi_if.S), 32'd2);
    lo_if.enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
